top_k_lane_dispatcher: RTL and testbench

// Packet-level round-robin scheduler between the packet parser's 33-bit word stream
// ({tlast, data[31:0]}) and NUM_LANES top-k compute lanes. Each whole packet goes to one

---
 rtl/top_k_lane_dispatcher.sv | 134 +++++++++++++
 tb/tb_top_k_lane_dispatcher.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/top_k_lane_dispatcher.sv
// top_k_lane_dispatcher
// Packet-level round-robin dispatcher from the parser word stream to NUM_LANES
// top-k lanes. Each whole packet is granted to the next enabled lane after the
// previous grant; a one-entry output register decouples lanes from the parser.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   enable[15:0]        lane enable mask (bits >= NUM_LANES ignored)
//   s_tdata/valid/ready input stream, s_tdata[32] = tlast
//   m_tdata             registered word shared by all lanes
//   m_tvalid/m_tready   per-lane handshake, m_tvalid one-hot or zero
//   cur_lane            lane granted to the current/last packet
//   busy, no_lane       STREAM state flag, IDLE-with-no-enabled-lane flag
//   pkt_count           completed packets (wraps)
//   last_pkt_words      word count of last completed packet (saturating)
module top_k_lane_dispatcher #(
    parameter int unsigned NUM_LANES = 16,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          enable,
    input  logic [32:0]          s_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    output logic [32:0]          m_tdata,
    output logic [NUM_LANES-1:0] m_tvalid,
    input  logic [NUM_LANES-1:0] m_tready,
    output logic [3:0]           cur_lane,
    output logic                 busy,
    output logic                 no_lane,
    output logic [CNT_W-1:0]     pkt_count,
    output logic [15:0]          last_pkt_words
);

    localparam int unsigned MASK_W = 16;
    localparam int unsigned LANE_W = 4;
    localparam int unsigned WCNT_W = 16;
    localparam logic [MASK_W-1:0] LANE_MASK = MASK_W'((64'd1 << NUM_LANES) - 64'd1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [MASK_W-1:0]   en_m;
    logic [MASK_W-1:0]   rdy_pad;
    logic [MASK_W-1:0]   vld_pad;
    logic [LANE_W-1:0]   grant;
    logic                grant_ok;
    logic                out_valid;
    logic                s_xfer;
    logic                m_xfer;
    logic                drain_last;
    logic [WCNT_W-1:0]   word_cnt;

    assign en_m       = enable & LANE_MASK;
    assign rdy_pad    = MASK_W'(m_tready);
    assign grant_ok   = |en_m;
    assign s_xfer     = s_tvalid & s_tready;
    assign m_xfer     = out_valid & rdy_pad[cur_lane];
    assign drain_last = m_xfer & m_tdata[32];
    assign m_tvalid   = vld_pad[NUM_LANES-1:0];

    // Round-robin search: walk downward so the nearest lane after cur_lane wins;
    // k == NUM_LANES lands on cur_lane itself, making it the last choice.
    always_comb begin
        grant = cur_lane;
        for (int unsigned k = NUM_LANES; k >= 1; k--) begin
            int unsigned idx;
            idx = (32'(cur_lane) + k) % NUM_LANES;
            if (en_m[idx[3:0]]) grant = LANE_W'(idx);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (s_tvalid && grant_ok) state_nxt = STREAM;
            STREAM:  if (drain_last)           state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs; once a tlast word sits in the register no further word is taken.
    always_comb begin
        s_tready          = 1'b0;
        no_lane           = 1'b0;
        busy              = 1'b0;
        vld_pad           = '0;
        vld_pad[cur_lane] = out_valid;
        case (state)
            IDLE:    no_lane = s_tvalid & ~grant_ok;
            STREAM: begin
                busy     = 1'b1;
                s_tready = ~out_valid | (rdy_pad[cur_lane] & ~m_tdata[32]);
            end
            default: ;
        endcase
    end

    // Grant, output register and packet statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            m_tdata        <= '0;
            cur_lane       <= LANE_W'(NUM_LANES - 1);
            word_cnt       <= '0;
            pkt_count      <= '0;
            last_pkt_words <= '0;
        end else begin
            if (state == IDLE && s_tvalid && grant_ok) begin
                cur_lane <= grant;
                word_cnt <= '0;
            end
            if (s_xfer) begin
                m_tdata <= s_tdata;
                if (word_cnt != {WCNT_W{1'b1}}) word_cnt <= word_cnt + WCNT_W'(1);
            end
            if (s_xfer)      out_valid <= 1'b1;
            else if (m_xfer) out_valid <= 1'b0;
            if (drain_last) begin
                pkt_count      <= pkt_count + CNT_W'(1);
                last_pkt_words <= word_cnt;
            end
        end
    end

endmodule

// File: tb/tb_top_k_lane_dispatcher.sv
// Testbench for top_k_lane_dispatcher: directed packet table, hand sequences
// for no-lane and mid-packet reset, and randomized packets against a
// transaction-level round-robin model.
module tb_top_k_lane_dispatcher;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] enable;
    logic [32:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [32:0] m_tdata;
    logic [15:0] m_tvalid;
    logic [15:0] m_tready;
    logic [3:0]  cur_lane;
    logic        busy;
    logic        no_lane;
    logic [31:0] pkt_count;
    logic [15:0] last_pkt_words;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: last granted lane and packet counter
    int cur_m = N - 1;
    int cnt_m = 0;

    top_k_lane_dispatcher #(.NUM_LANES(N), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .cur_lane(cur_lane), .busy(busy), .no_lane(no_lane),
        .pkt_count(pkt_count), .last_pkt_words(last_pkt_words)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          do_reset;
        logic [15:0] en;
        logic [15:0] en_mid;
        int          nwords;
        int          rmode;
        int          exp_lane;
        int          exp_cnt;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic [15:0] en);
        for (int k = 1; k <= N; k++) begin
            int l;
            l = (cur_m + k) % N;
            if (en[l]) return l;
        end
        return -1;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_s_tready"}, 64'(s_tready), 0);
        check({tag, "_m_tvalid"}, 64'(m_tvalid), 0);
        check({tag, "_m_tdata"},  64'(m_tdata), 0);
        check({tag, "_cur_lane"}, 64'(cur_lane), 64'(N - 1));
        check({tag, "_busy"},     64'(busy), 0);
        check({tag, "_no_lane"},  64'(no_lane), 0);
        check({tag, "_pkt_count"}, 64'(pkt_count), 0);
        check({tag, "_last_words"}, 64'(last_pkt_words), 0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_vals(tag);
        rst = 1'b0;
        cur_m = N - 1;
        cnt_m = 0;
    endtask

    // Drives one packet and checks every delivered word, its lane and the
    // resulting statistics. rmode: 0 ready, 1 toggling, 2 random.
    // vmode: 0 continuous valid, 1 random valid gaps.
    task automatic send_packet(input int nwords, input logic [15:0] en, input logic [15:0] en_mid,
                               input int rmode, input int vmode, input int exp_lane,
                               input int exp_cnt, input string tag);
        logic [32:0] words[$];
        int in_idx = 0;
        int out_idx = 0;
        int cyc = 0;
        bit pend = 1'b0;
        for (int i = 0; i < nwords; i++) words.push_back({(i == nwords - 1), 32'($urandom)});
        enable = en;
        while (out_idx < nwords && cyc < 300) begin
            @(posedge clk); #1;
            if (in_idx < nwords) begin
                if (!pend) pend = (vmode == 0) || ($urandom_range(3) != 0);
                s_tvalid = pend;
                s_tdata  = words[in_idx];
            end else begin
                s_tvalid = 1'b0;
                s_tdata  = '0;
            end
            case (rmode)
                0:       m_tready = '1;
                1:       m_tready = (cyc % 2 == 0) ? 16'hFFFF : 16'h0000;
                default: m_tready = 16'($urandom);
            endcase
            @(negedge clk);
            if (m_tvalid != 0) begin
                check({tag, "_m_tvalid_lane"}, 64'(m_tvalid), 64'(16'(1) << exp_lane));
                if (out_idx < nwords) check({tag, "_m_tdata"}, 64'(m_tdata), 64'(words[out_idx]));
                else check({tag, "_extra_word"}, 64'(m_tvalid), 0);
                if (m_tdata[32]) check({tag, "_s_tready_after_tlast"}, 64'(s_tready), 0);
                if (m_tready[exp_lane] && m_tvalid[exp_lane]) out_idx++;
            end
            if (s_tvalid && s_tready) begin
                in_idx++;
                pend = 1'b0;
                if (in_idx == 1) enable = en_mid;
            end
            cyc++;
        end
        if (out_idx < nwords) check({tag, "_timeout_words"}, 64'(out_idx), 64'(nwords));
        @(posedge clk); #1;
        s_tvalid = 1'b0; m_tready = '0;
        @(negedge clk);
        check({tag, "_pkt_count"},  64'(pkt_count), 64'(exp_cnt));
        check({tag, "_last_words"}, 64'(last_pkt_words), 64'(nwords));
        check({tag, "_cur_lane"},   64'(cur_lane), 64'(exp_lane));
        check({tag, "_busy_idle"},  64'(busy), 0);
        cur_m = exp_lane;
        cnt_m = exp_cnt;
    endtask

    initial begin
        vec_t vecs[$];
        logic [32:0] w;
        int in_idx;
        int guard;

        rst = 1'b1; enable = '0; s_tdata = '0; s_tvalid = 1'b0; m_tready = '0;

        // T1, T2, T4, T5 and single-lane behaviour
        vecs.push_back('{1'b1, 16'h000F, 16'h000F, 3, 0, 0, 1});
        vecs.push_back('{1'b0, 16'h000F, 16'h000F, 3, 0, 1, 2});
        vecs.push_back('{1'b0, 16'h000F, 16'h000F, 3, 0, 2, 3});
        vecs.push_back('{1'b0, 16'h000F, 16'h000F, 3, 0, 3, 4});
        vecs.push_back('{1'b1, 16'h0022, 16'h0022, 1, 0, 1, 1});
        vecs.push_back('{1'b0, 16'h0022, 16'h0022, 1, 0, 5, 2});
        vecs.push_back('{1'b0, 16'h0022, 16'h0022, 1, 0, 1, 3});
        vecs.push_back('{1'b1, 16'h0001, 16'h0001, 8, 1, 0, 1});
        vecs.push_back('{1'b1, 16'h0003, 16'h0002, 5, 0, 0, 1});
        vecs.push_back('{1'b0, 16'h0002, 16'h0002, 2, 0, 1, 2});
        vecs.push_back('{1'b0, 16'h0080, 16'h0080, 2, 0, 7, 3});
        vecs.push_back('{1'b0, 16'h0080, 16'h0080, 4, 2, 7, 4});

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].do_reset) do_reset($sformatf("v%0d_rst", i));
            send_packet(vecs[i].nwords, vecs[i].en, vecs[i].en_mid, vecs[i].rmode, 0,
                        vecs[i].exp_lane, vecs[i].exp_cnt, $sformatf("v%0d", i));
        end

        // T3: no enabled lane holds the word, then lane 8 appears
        do_reset("t3_rst");
        w = {1'b1, 32'hCAFE_0003};
        @(posedge clk); #1;
        enable = '0; s_tvalid = 1'b1; s_tdata = w; m_tready = '1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t3_no_lane", 64'(no_lane), 1);
            check("t3_s_tready", 64'(s_tready), 0);
            check("t3_pkt_count", 64'(pkt_count), 0);
            @(posedge clk); #1;
        end
        enable = 16'h0100;
        @(negedge clk);
        check("t3_no_lane_clear", 64'(no_lane), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t3_busy", 64'(busy), 1);
        check("t3_cur_lane", 64'(cur_lane), 8);
        check("t3_s_tready", 64'(s_tready), 1);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        @(negedge clk);
        check("t3_m_tvalid", 64'(m_tvalid), 64'(16'h0100));
        check("t3_m_tdata", 64'(m_tdata), 64'(w));
        @(posedge clk); #1;
        @(negedge clk);
        check("t3_pkt_count_done", 64'(pkt_count), 1);
        check("t3_last_words", 64'(last_pkt_words), 1);
        cur_m = 8; cnt_m = 1;

        // T6: reset on the fourth word of a ten-word packet
        do_reset("t6_rst0");
        enable = 16'h0001; m_tready = '1;
        in_idx = 0; guard = 0;
        while (in_idx < 4 && guard < 50) begin
            @(posedge clk); #1;
            s_tvalid = 1'b1;
            s_tdata  = {1'b0, 32'h6000_0000 + 32'(in_idx)};
            @(negedge clk);
            if (s_tvalid && s_tready) in_idx++;
            guard++;
        end
        check("t6_words_in", 64'(in_idx), 4);
        do_reset("t6_midrst");
        send_packet(3, 16'h0001, 16'h0001, 0, 0, 0, 1, "t6_next");

        // Randomized packets against the round-robin model
        do_reset("rnd_rst");
        for (int p = 0; p < 40; p++) begin
            logic [15:0] en;
            int nw;
            en = 16'($urandom);
            if (p % 5 == 0) en = 16'(1) << $urandom_range(N - 1);
            if (en == 0) en = 16'h8000;
            nw = $urandom_range(1, 6);
            send_packet(nw, en, 16'($urandom), 2, 1, model_grant(en), cnt_m + 1,
                        $sformatf("rnd%0d", p));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
